// File: rtl/decode_idex_stage_if.sv
// ----------------------------------------------------------------------------
// decode_idex_stage_if
// Bundles the signals around the decode stage: IF/ID inputs, per-instruction
// decode controls, pipeline controls (stall/flush), MEM/WB writeback, and the
// registered ID/EX outputs plus hazard/error flags.
//   master : drives IF/ID, decode, pipeline-control and writeback signals;
//            observes the ID/EX outputs
//   slave  : the decode stage itself
// ----------------------------------------------------------------------------
interface decode_idex_stage_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CTRL_W = 12
);
    // IF/ID side
    logic              valid_if;
    logic [15:0]       instr_if;
    logic [DATA_W-1:0] pc2_if;
    logic [CTRL_W-1:0] ctrl_if;
    // Decode controls
    logic [1:0]        reg_dst;
    logic [1:0]        imm_size;
    logic              zero_ext;
    logic              uses_rs;
    logic              uses_rt;
    logic              reg_write;
    logic              mem_write;
    logic              mem_read;
    // Pipeline control
    logic              stall;
    logic              flush;
    // Writeback
    logic              wb_en;
    logic [2:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    // ID/EX outputs
    logic [DATA_W-1:0] pc2_ex;
    logic [DATA_W-1:0] rd1_ex;
    logic [DATA_W-1:0] rd2_ex;
    logic [DATA_W-1:0] imm_ex;
    logic [CTRL_W-1:0] ctrl_ex;
    logic [2:0]        wr_addr_ex;
    logic [2:0]        rs_addr_ex;
    logic [2:0]        rt_addr_ex;
    logic              reg_write_ex;
    logic              mem_write_ex;
    logic              mem_read_ex;
    logic              valid_ex;
    logic              load_use_stall;
    logic              err;

    modport master (
        output valid_if, instr_if, pc2_if, ctrl_if, reg_dst, imm_size, zero_ext,
               uses_rs, uses_rt, reg_write, mem_write, mem_read, stall, flush,
               wb_en, wb_addr, wb_data,
        input  pc2_ex, rd1_ex, rd2_ex, imm_ex, ctrl_ex, wr_addr_ex, rs_addr_ex,
               rt_addr_ex, reg_write_ex, mem_write_ex, mem_read_ex, valid_ex,
               load_use_stall, err
    );

    modport slave (
        input  valid_if, instr_if, pc2_if, ctrl_if, reg_dst, imm_size, zero_ext,
               uses_rs, uses_rt, reg_write, mem_write, mem_read, stall, flush,
               wb_en, wb_addr, wb_data,
        output pc2_ex, rd1_ex, rd2_ex, imm_ex, ctrl_ex, wr_addr_ex, rs_addr_ex,
               rt_addr_ex, reg_write_ex, mem_write_ex, mem_read_ex, valid_ex,
               load_use_stall, err
    );
endinterface

// File: rtl/decode_idex_stage.sv
// ----------------------------------------------------------------------------
// decode_idex_stage
// Decode stage with integrated ID/EX pipeline register. Holds an 8-entry
// register file (optional write-through bypass), extends immediates, selects
// the destination register, detects load-use hazards and applies
// hold/flush/bubble on the ID/EX boundary.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (clears ID/EX, err and register file)
//   bus  : decode_idex_stage_if.slave - IF/ID inputs, decode controls,
//          stall/flush, writeback, registered ID/EX outputs, load_use_stall,
//          sticky err
// ----------------------------------------------------------------------------
module decode_idex_stage #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CTRL_W    = 12,
    parameter bit          BYPASS_EN = 1'b1
) (
    input logic                clk,
    input logic                rst,
    decode_idex_stage_if.slave bus
);

    logic [DATA_W-1:0] rf_q [8];

    logic [2:0]        rs, rt, wr_addr;
    logic [DATA_W-1:0] rd1, rd2, imm;
    logic              sign_ext;
    logic              lus;

    logic [DATA_W-1:0] pc2_q, pc2_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [2:0]        wr_q, wr_d, rs_q, rs_d, rt_q, rt_d;
    logic              rw_q, rw_d, mw_q, mw_d, mr_q, mr_d, valid_q, valid_d;
    logic              err_q, err_d;

    // Register file: write is independent of any pipeline control.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else if (bus.wb_en) begin
            rf_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Decode: read ports with optional bypass, immediate, destination.
    always_comb begin
        rs       = bus.instr_if[10:8];
        rt       = bus.instr_if[7:5];
        rd1      = (BYPASS_EN && bus.wb_en && bus.wb_addr == rs) ? bus.wb_data : rf_q[rs];
        rd2      = (BYPASS_EN && bus.wb_en && bus.wb_addr == rt) ? bus.wb_data : rf_q[rt];
        sign_ext = ~bus.zero_ext;

        imm = '0;
        unique case (bus.imm_size)
            2'b00: imm = {{(DATA_W-5){sign_ext & bus.instr_if[4]}}, bus.instr_if[4:0]};
            2'b01: imm = {{(DATA_W-8){sign_ext & bus.instr_if[7]}}, bus.instr_if[7:0]};
            2'b10: imm = {{(DATA_W-11){sign_ext & bus.instr_if[10]}}, bus.instr_if[10:0]};
            2'b11: imm = '0; // illegal size; flagged via err
        endcase

        wr_addr = 3'd0;
        unique case (bus.reg_dst)
            2'b00: wr_addr = bus.instr_if[7:5];
            2'b01: wr_addr = bus.instr_if[4:2];
            2'b10: wr_addr = bus.instr_if[10:8];
            2'b11: wr_addr = 3'd7;
        endcase
    end

    // Load in EX whose destination is read by the instruction in ID.
    assign lus = valid_q & mr_q & rw_q & bus.valid_if &
                 ((bus.uses_rs & (wr_q == rs)) | (bus.uses_rt & (wr_q == rt)));

    // ID/EX next state: flush > stall > load-use bubble > normal load.
    always_comb begin
        pc2_d   = pc2_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        wr_d    = wr_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rw_d    = rw_q;
        mw_d    = mw_q;
        mr_d    = mr_q;
        valid_d = valid_q;

        if (bus.flush || (!bus.stall && lus) || !bus.stall) begin
            // Data fields always take decoded values when not holding.
            pc2_d  = bus.pc2_if;
            rd1_d  = rd1;
            rd2_d  = rd2;
            imm_d  = imm;
            ctrl_d = bus.ctrl_if;
            wr_d   = wr_addr;
            rs_d   = rs;
            rt_d   = rt;
        end

        if (bus.flush || (!bus.stall && lus)) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mw_d    = 1'b0;
            mr_d    = 1'b0;
        end else if (bus.stall) begin
            // Held operands still pick up a writeback that targets them.
            if (BYPASS_EN && bus.wb_en && bus.wb_addr == rs_q) rd1_d = bus.wb_data;
            if (BYPASS_EN && bus.wb_en && bus.wb_addr == rt_q) rd2_d = bus.wb_data;
        end else begin
            valid_d = bus.valid_if;
            rw_d    = bus.reg_write & bus.valid_if;
            mw_d    = bus.mem_write & bus.valid_if;
            mr_d    = bus.mem_read & bus.valid_if;
        end

        err_d = err_q | (bus.valid_if & (bus.imm_size == 2'b11) & ~bus.flush);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc2_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            wr_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rw_q    <= 1'b0;
            mw_q    <= 1'b0;
            mr_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc2_q   <= pc2_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            wr_q    <= wr_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rw_q    <= rw_d;
            mw_q    <= mw_d;
            mr_q    <= mr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.pc2_ex         = pc2_q;
    assign bus.rd1_ex         = rd1_q;
    assign bus.rd2_ex         = rd2_q;
    assign bus.imm_ex         = imm_q;
    assign bus.ctrl_ex        = ctrl_q;
    assign bus.wr_addr_ex     = wr_q;
    assign bus.rs_addr_ex     = rs_q;
    assign bus.rt_addr_ex     = rt_q;
    assign bus.reg_write_ex   = rw_q;
    assign bus.mem_write_ex   = mw_q;
    assign bus.mem_read_ex    = mr_q;
    assign bus.valid_ex       = valid_q;
    assign bus.load_use_stall = lus;
    assign bus.err            = err_q;

endmodule

// File: doc/decode_idex_stage.md
Name: decode_idex_stage

Overview:
Parametrised decode stage with an integrated ID/EX pipeline register. It holds an 8-entry register file with optional write-through bypass and does immediate extension and destination-register selection. It also detects load-use hazards and handles hold, flush and bubble insertion on the ID/EX boundary. It sits between the IF/ID register and the execute stage, and takes writeback from the MEM/WB stage.

Parameters:
DATA_W, 16, datapath/register width; must be >= 16
CTRL_W, 12, width of the opaque control bundle carried unmodified to EX
BYPASS_EN, 1, 1 = same-cycle writeback data is forwarded to read ports and into held ID/EX operands

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_if  in  1  IF/ID holds a real instruction
instr_if  in  16  instruction word
pc2_if  in  DATA_W  PC+2 of the instruction
ctrl_if  in  CTRL_W  opaque control bundle (ALU op, branch, jump, etc.)
reg_dst  in  2  destination select: 00 instr[7:5], 01 instr[4:2], 10 instr[10:8], 11 r7
imm_size  in  2  00 5-bit, 01 8-bit, 10 11-bit, 11 illegal
zero_ext  in  1  1 = zero-extend, 0 = sign-extend the immediate
uses_rs, uses_rt  in  1 each  instruction reads instr[10:8] / instr[7:5]
reg_write, mem_write, mem_read  in  1 each  instruction enables
stall  in  1  downstream hold: ID/EX keeps its contents
flush  in  1  taken branch/jump: ID/EX becomes a bubble
wb_en  in  1  register-file write enable
wb_addr  in  3  write address
wb_data  in  DATA_W  write data
pc2_ex, rd1_ex, rd2_ex, imm_ex  out  DATA_W  registered operands
ctrl_ex  out  CTRL_W  registered control bundle
wr_addr_ex, rs_addr_ex, rt_addr_ex  out  3 each  registered register addresses
reg_write_ex, mem_write_ex, mem_read_ex, valid_ex  out  1 each  registered enables and valid flag
load_use_stall  out  1  combinational; upstream must hold IF/ID and PC
err  out  1  sticky error flag

Behaviour:
- The register file has 8 x DATA_W entries. r0 is an ordinary register. It is written at posedge when wb_en is high.
- Reads are combinational on rs = instr[10:8] and rt = instr[7:5].
- With BYPASS_EN=1: if wb_en is high and wb_addr equals a read address, that read port returns wb_data.
- Immediate: the selected field instr[4:0], [7:0] or [10:0] is sign- or zero-extended to DATA_W. imm_size=11 gives imm=0.
- load_use_stall = valid_ex & mem_read_ex & reg_write_ex & valid_if & ((uses_rs & wr_addr_ex==rs) | (uses_rt & wr_addr_ex==rt)).
- ID/EX update each posedge, in priority order:
  1. rst: all outputs 0, including err. Every register-file entry is cleared to 0.
  2. flush: load a bubble.
  3. stall: hold all fields. Exception: with BYPASS_EN=1 and wb_en high, rd1_ex loads wb_data when wb_addr==rs_addr_ex, and rd2_ex loads wb_data when wb_addr==rt_addr_ex.
  4. load_use_stall: load a bubble.
  5. Otherwise: load decoded values, with valid_ex=valid_if. Each enable output is its input ANDed with valid_if.
- Bubble: valid_ex, reg_write_ex, mem_write_ex and mem_read_ex are 0. The other fields take the decoded values and are don't-care.
- Latency: one cycle, ID to EX outputs.
- The register-file write is independent of stall, flush and load_use_stall. A write under rst is ignored.
- err sets at a posedge when valid_if=1 and imm_size=11 and the stage is not being flushed. err stays set until rst.
- Simultaneous stall and load_use_stall: stall wins (hold). load_use_stall remains asserted, so the bubble goes in on the first unstalled cycle.

Test Plan:
- Bypass: write r3=0xBEEF with wb_en=1 in the same cycle that instr reads rs=3 -> next cycle rd1_ex=0xBEEF. With BYPASS_EN=0 -> rd1_ex=old r3 (0 after reset).
- Immediate: instr[4:0]=5'b10110, imm_size=00. zero_ext=0 -> imm_ex=0xFFF6; zero_ext=1 -> 0x0016. imm_size=10, instr[10:0]=0x400, sign -> 0xFC00.
- Load-use: a load to r2 is in EX (mem_read_ex=1, wr_addr_ex=2) and the next instruction reads r2 via uses_rt -> load_use_stall=1. The next cycle valid_ex=0 with all enables 0. The held instruction then issues with the correct operands.
- Stall with writeback: ID/EX holds rs_addr_ex=5 under stall=1 for 3 cycles; wb writes r5=0x1234 in cycle 2 -> rd1_ex=0x1234 after cycle 2; all other fields unchanged.
- Flush priority: flush=1 and stall=1 together with mem_write=1 -> next cycle mem_write_ex=0 and valid_ex=0.
- Error and reset: valid_if=1, imm_size=11 -> err=1 and stays 1. Assert rst mid-stream -> all outputs 0, err=0, and a read of r3 returns 0.
